// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy detector for a serial PAT_LEN-bit pattern with a saturating match counter.
// The KMP-style transition table is built at elaboration from PATTERN; nothing is loaded at runtime.
module mealy_seq_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = ($clog2(PAT_LEN) < 1) ? 1 : $clog2(PAT_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clear,
  output logic [SW-1:0]    state,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int TBL = 2 ** SW;

  // j-th received bit of the pattern (MSB arrives first)
  function automatic logic f_pat_bit(input int j);
    logic [31:0] p;
    p = 32'(PATTERN);
    return p[5'(PAT_LEN - 1 - j)];
  endfunction

  // Longest k <= kmax such that the last k bits of seq[0..n-1] equal the first k pattern bits
  function automatic int f_suffix(input logic [31:0] seq, input int n, input int kmax);
    int  best;
    bit  ok;
    best = 0;
    for (int k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (seq[5'(n - k + j)] != f_pat_bit(j)) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic int f_border();
    logic [31:0] seq;
    seq = '0;
    for (int j = 0; j < PAT_LEN; j++) seq[5'(j)] = f_pat_bit(j);
    return f_suffix(seq, PAT_LEN, PAT_LEN - 1);
  endfunction

  // Next prefix length after consuming bit b with s prefix bits already matched
  function automatic logic [SW-1:0] f_next(input int s, input logic b);
    logic [31:0] seq;
    int          k;
    seq = '0;
    for (int j = 0; j < s; j++) seq[5'(j)] = f_pat_bit(j);
    seq[5'(s)] = b;
    k = f_suffix(seq, s + 1, s + 1);
    if (k == PAT_LEN) k = OVERLAP ? f_border() : 0;
    return SW'(k);
  endfunction

  logic [SW-1:0]    w_nxt0 [TBL];
  logic [SW-1:0]    w_nxt1 [TBL];
  logic [SW-1:0]    w_nxt;
  logic             w_out;
  logic [SW-1:0]    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  for (genvar s = 0; s < TBL; s++) begin : g_tbl
    if (s < PAT_LEN) begin : g_live
      assign w_nxt0[s] = f_next(s, 1'b0);
      assign w_nxt1[s] = f_next(s, 1'b1);
    end else begin : g_dead
      assign w_nxt0[s] = '0;
      assign w_nxt1[s] = '0;
    end
  end

  assign w_nxt = in ? w_nxt1[r_state] : w_nxt0[r_state];
  assign w_out = in_valid & ~rst & ~clear & (r_state == SW'(PAT_LEN - 1)) & (in == PATTERN[0]);

  always_ff @(posedge clk) begin
    if (rst)           r_state <= '0;
    else if (clear)    r_state <= '0;
    else if (in_valid) r_state <= w_nxt;
  end

  // Counter holds at all-ones; the sticky flag rises on the edge that reaches it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_out && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == {{(CNT_W-1){1'b1}}, 1'b0}) r_sat <= 1'b1;
    end
  end

  assign state     = r_state;
  assign out       = w_out;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Four detector configurations share one stimulus stream; a suffix/prefix reference model predicts each.
module tb_mealy_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, vld, din;

  localparam int ND = 4;
  localparam int LEN [ND] = '{4, 4, 4, 7};
  localparam int PAT [ND] = '{'hB, 'hB, 'hB, 'h6D};
  localparam int OVL [ND] = '{1, 0, 1, 1};
  localparam int CW  [ND] = '{8, 8, 2, 8};

  logic [1:0] st_a, st_b, st_c;
  logic [2:0] st_d;
  logic [7:0] cnt_a, cnt_b, cnt_d;
  logic [1:0] cnt_c;
  logic [ND-1:0] w_o, w_sat;
  int w_st [ND];
  int w_cnt [ND];

  mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(vld), .in(din), .clear(clr),
    .state(st_a), .out(w_o[0]), .match_cnt(cnt_a), .cnt_sat(w_sat[0]));
  mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(vld), .in(din), .clear(clr),
    .state(st_b), .out(w_o[1]), .match_cnt(cnt_b), .cnt_sat(w_sat[1]));
  mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(vld), .in(din), .clear(clr),
    .state(st_c), .out(w_o[2]), .match_cnt(cnt_c), .cnt_sat(w_sat[2]));
  mealy_seq_detector #(.PAT_LEN(7), .PATTERN(7'b1101101), .OVERLAP(1'b1), .CNT_W(8)) u_d (
    .clk(clk), .rst(rst), .in_valid(vld), .in(din), .clear(clr),
    .state(st_d), .out(w_o[3]), .match_cnt(cnt_d), .cnt_sat(w_sat[3]));

  assign w_st[0] = int'(st_a);   assign w_st[1] = int'(st_b);
  assign w_st[2] = int'(st_c);   assign w_st[3] = int'(st_d);
  assign w_cnt[0] = int'(cnt_a); assign w_cnt[1] = int'(cnt_b);
  assign w_cnt[2] = int'(cnt_c); assign w_cnt[3] = int'(cnt_d);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: recent consumed bits (LSB newest) and how many are valid since the last restart
  int m_hist [ND];
  int m_n    [ND];
  int m_cnt  [ND];
  bit m_sat  [ND];

  function automatic bit m_match(input int h, input int n, input int i);
    return (n >= LEN[i]) && ((h & ((1 << LEN[i]) - 1)) == PAT[i]);
  endfunction

  // Longest proper pattern prefix that is a suffix of the history
  function automatic int m_state(input int i);
    int best = 0;
    for (int k = 1; k < LEN[i] && k <= m_n[i]; k++)
      if ((m_hist[i] & ((1 << k) - 1)) == (PAT[i] >> (LEN[i] - k))) best = k;
    return best;
  endfunction

  task automatic step(input bit r, input bit c, input bit v, input bit b);
    int h2, n2;
    bit eo;
    rst = r; clr = c; vld = v; din = b;
    #1;
    for (int i = 0; i < ND; i++) begin
      h2 = ((m_hist[i] << 1) | int'(b)) & 'hFFFF;
      n2 = (m_n[i] < 16) ? m_n[i] + 1 : 16;
      eo = !r && !c && v && m_match(h2, n2, i);
      chk($sformatf("out[%0d]", i), int'(w_o[i]), int'(eo));
      if (r) begin
        m_hist[i] = 0; m_n[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0;
      end else if (c) begin
        m_n[i] = 0;
      end else if (v) begin
        if (eo) begin
          if (m_cnt[i] < (1 << CW[i]) - 1) m_cnt[i]++;
          if (m_cnt[i] == (1 << CW[i]) - 1) m_sat[i] = 1'b1;
          if (OVL[i] == 0) n2 = 0;
        end
        m_hist[i] = h2;
        m_n[i]    = n2;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("state[%0d]", i), w_st[i], m_state(i));
      chk($sformatf("cnt[%0d]", i), w_cnt[i], m_cnt[i]);
      chk($sformatf("sat[%0d]", i), int'(w_sat[i]), int'(m_sat[i]));
    end
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int j = n - 1; j >= 0; j--) step(1'b0, 1'b0, 1'b1, bits[4'(j)]);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; vld = 1'b0; din = 1'b0;
    for (int i = 0; i < ND; i++) begin
      m_hist[i] = 0; m_n[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0;
    end
    do_reset();
    do_reset();
    chk("rst_state_a", w_st[0], 0);
    chk("rst_cnt_a", w_cnt[0], 0);

    feed(16'b1011011, 7);
    chk("ovl_cnt_a", w_cnt[0], 2);
    chk("ovl_state_a", w_st[0], 1);
    chk("novl_cnt_b", w_cnt[1], 1);
    chk("novl_state_b", w_st[1], 1);

    do_reset();
    feed(16'b101011, 6);
    chk("kmp_cnt_a", w_cnt[0], 1);

    do_reset();
    feed(16'b101, 3);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)));
    chk("gap_state_a", w_st[0], 3);
    feed(16'b011, 3);
    chk("gap_cnt_a", w_cnt[0], 1);

    do_reset();
    feed(16'b101, 3);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("midrst_cnt_a", w_cnt[0], 0);
    chk("midrst_state_a", w_st[0], 0);

    do_reset();
    feed(16'b1011101, 7);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt_a", w_cnt[0], 1);
    chk("clr_state_a", w_st[0], 0);

    do_reset();
    for (int k = 0; k < 5; k++) feed(16'b1011, 4);
    chk("sat_cnt_c", w_cnt[2], 3);
    chk("sat_flag_c", int'(w_sat[2]), 1);
    chk("nosat_cnt_a", w_cnt[0], 5);

    do_reset();
    feed(16'b1101101101, 10);
    chk("len7_cnt_d", w_cnt[3], 2);
    chk("len7_state_d", w_st[3], 4);

    for (int k = 0; k < 3000; k++) begin
      int rr = int'($urandom_range(199));
      step(rr < 2, (rr >= 2) && (rr < 7), $urandom_range(9) < 7, 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
